// File: rtl/subpel_hfilter_stream.sv
// Row-streaming HEVC luma horizontal sub-pel filter (a/b/c), 2-stage pipeline.
// SUBPEL_INTERMEDIATE_EN: emit raw signed 16-bit sums instead of clipped 8-bit.
module subpel_hfilter_stream #(
    parameter int BLK  = 8,
    parameter int ROWS = BLK,
    parameter int PW   = 8,
`ifdef SUBPEL_INTERMEDIATE_EN
    localparam int OW  = 16,
`else
    localparam int OW  = 8,
`endif
    localparam int RW  = $clog2(ROWS),
    localparam int AW  = PW + 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [RW-1:0]           next_row,
    input  logic [(BLK+7)*PW-1:0]   in_row,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [BLK*OW-1:0]       out_a,
    output logic [BLK*OW-1:0]       out_b,
    output logic [BLK*OW-1:0]       out_c,
    output logic [RW-1:0]           out_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam int TA [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
    localparam int TB [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
    localparam int TC [8] = '{0, 1, -5, 17, 58, -10, 4, -1};

    state_t state;

    logic                    stall;
    logic                    in_fire;
    logic                    s1_valid;
    logic [RW-1:0]           s1_row;
    logic [BLK-1:0][AW-1:0]  s1_a, s1_b, s1_c;
    logic [BLK-1:0][AW-1:0]  sum_a, sum_b, sum_c;
    logic [BLK*OW-1:0]       nx_a, nx_b, nx_c;

    function automatic logic [AW-1:0] fir(
        input logic [(BLK+7)*PW-1:0] row,
        input int                    j,
        input int                    sel
    );
        int acc;
        int c;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            c = (sel == 0) ? TA[k] : (sel == 1) ? TB[k] : TC[k];
            acc += c * int'({1'b0, row[PW*(j+k) +: PW]});
        end
        return AW'(acc);
    endfunction

    function automatic logic [OW-1:0] outp(input logic signed [AW-1:0] s);
`ifdef SUBPEL_INTERMEDIATE_EN
        return OW'(32'(s));
`else
        logic signed [AW-1:0] r;
        r = (s + AW'(32)) >>> 6;
        if (r < 0)
            return '0;
        if (r > AW'(255))
            return 8'hFF;
        return r[7:0];
`endif
    endfunction

    assign stall    = out_valid && !out_ready;
    assign in_ready = (state == RUN) && !stall;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        sum_a = '0;
        sum_b = '0;
        sum_c = '0;
        nx_a  = '0;
        nx_b  = '0;
        nx_c  = '0;
        for (int j = 0; j < BLK; j++) begin
            sum_a[j] = fir(in_row, j, 0);
            sum_b[j] = fir(in_row, j, 1);
            sum_c[j] = fir(in_row, j, 2);
            nx_a[OW*j +: OW] = outp(s1_a[j]);
            nx_b[OW*j +: OW] = outp(s1_b[j]);
            nx_c[OW*j +: OW] = outp(s1_c[j]);
        end
    end

    // Whole pipeline advances together; a stalled output freezes S1 too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_row    <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_c      <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
        end else if (!stall) begin
            s1_valid  <= in_fire;
            out_valid <= s1_valid;
            if (in_fire) begin
                s1_row <= next_row;
                s1_a   <= sum_a;
                s1_b   <= sum_b;
                s1_c   <= sum_c;
            end
            if (s1_valid) begin
                out_row <= s1_row;
                out_a   <= nx_a;
                out_b   <= nx_b;
                out_c   <= nx_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            next_row <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        next_row <= '0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        if (next_row == RW'(ROWS-1))
                            state <= DRAIN;
                        else
                            next_row <= next_row + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && out_row == RW'(ROWS-1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    next_row <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
